// File: rtl/jfpjc_pkg.sv
// Shared constants and state encoding for the jfpjc entropy output path.
package jfpjc_pkg;

  localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
  localparam logic [7:0] JPEG_EOI           = 8'hD9;
  localparam logic [7:0] JPEG_STUFF         = 8'h00;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EMIT   = 3'd1,
    STUFF  = 3'd2,
    EOI_FF = 3'd3,
    EOI_D9 = 3'd4
  } stuffer_state_e;

endpackage

// File: rtl/jfpjc_byte_stuffer.sv
// Serialises packed Huffman words into a JPEG scan byte stream,
// inserting 0x00 after every 0xFF data byte and optionally appending EOI.
module jfpjc_byte_stuffer
  import jfpjc_pkg::*;
#(
  parameter bit          APPEND_EOI  = 1'b1,
  parameter int unsigned COUNT_WIDTH = 24
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            data_in,
  input  logic                   data_in_valid,
  output logic                   data_in_ready,
  input  logic                   data_in_last,
  input  logic [2:0]             data_in_nbytes,
  output logic [7:0]             byte_out,
  output logic                   byte_out_valid,
  input  logic                   byte_out_ready,
  output logic                   byte_out_last,
  output logic [COUNT_WIDTH-1:0] byte_count,
  output logic [COUNT_WIDTH-1:0] stuff_count
);

  stuffer_state_e state, state_next, after_lane;
  logic [31:0] word, word_next;
  logic        word_last, word_last_next;
  logic [2:0]  rem, rem_next, in_rem;
  logic [1:0]  lane, lane_next;
  logic [7:0]  lane_byte, byte_next;
  logic        valid_next, olast_next;
  logic        accept, xfer, more_lanes, final_lane_next;

  assign data_in_ready = (state == IDLE);
  assign accept        = data_in_valid && data_in_ready;
  assign xfer          = byte_out_valid && byte_out_ready;
  // Non-last words always carry four bytes; oversized counts saturate at four.
  assign in_rem        = !data_in_last ? 3'd4 :
                         (data_in_nbytes > 3'd4) ? 3'd4 : data_in_nbytes;
  assign more_lanes    = (3'(lane) + 3'd1) < rem;

  always_comb begin
    after_lane = IDLE;
    if (more_lanes)
      after_lane = EMIT;
    else if (word_last && APPEND_EOI)
      after_lane = EOI_FF;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_rem != 3'd0)
            state_next = EMIT;
          else if (data_in_last && APPEND_EOI)
            state_next = EOI_FF;
        end
      end
      EMIT: begin
        if (xfer)
          state_next = (byte_out == JPEG_MARKER_PREFIX) ? STUFF : after_lane;
      end
      STUFF:  if (xfer) state_next = after_lane;
      EOI_FF: if (xfer) state_next = EOI_D9;
      EOI_D9: if (xfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    word_next      = word;
    word_last_next = word_last;
    rem_next       = rem;
    lane_next      = lane;
    if (accept) begin
      word_next      = data_in;
      word_last_next = data_in_last;
      rem_next       = in_rem;
      lane_next      = 2'd0;
    end else if (xfer && more_lanes &&
                 (state == STUFF || (state == EMIT && byte_out != JPEG_MARKER_PREFIX))) begin
      lane_next = lane + 2'd1;
    end

    case (lane_next)
      2'd0:    lane_byte = word_next[7:0];
      2'd1:    lane_byte = word_next[15:8];
      2'd2:    lane_byte = word_next[23:16];
      default: lane_byte = word_next[31:24];
    endcase

    final_lane_next = (3'(lane_next) + 3'd1) == rem_next;

    byte_next = byte_out;
    case (state_next)
      EMIT:    byte_next = lane_byte;
      STUFF:   byte_next = JPEG_STUFF;
      EOI_FF:  byte_next = JPEG_MARKER_PREFIX;
      EOI_D9:  byte_next = JPEG_EOI;
      default: byte_next = byte_out;
    endcase

    valid_next = (state_next != IDLE);

    if (APPEND_EOI)
      olast_next = (state_next == EOI_D9);
    else
      olast_next = word_last_next && final_lane_next &&
                   ((state_next == EMIT && lane_byte != JPEG_MARKER_PREFIX) ||
                    state_next == STUFF);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      word           <= '0;
      word_last      <= 1'b0;
      rem            <= '0;
      lane           <= '0;
      byte_out       <= '0;
      byte_out_valid <= 1'b0;
      byte_out_last  <= 1'b0;
      byte_count     <= '0;
      stuff_count    <= '0;
    end else begin
      state          <= state_next;
      word           <= word_next;
      word_last      <= word_last_next;
      rem            <= rem_next;
      lane           <= lane_next;
      byte_out       <= byte_next;
      byte_out_valid <= valid_next;
      byte_out_last  <= olast_next;
      if (xfer)
        byte_count <= byte_count + COUNT_WIDTH'(1);
      if (xfer && state == STUFF)
        stuff_count <= stuff_count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_jfpjc_byte_stuffer.sv
// Directed self-checking bench for jfpjc_byte_stuffer (EOI on and off instances).
module tb_jfpjc_byte_stuffer;

  localparam int unsigned CW = 24;

  logic          clock = 1'b0;
  logic          reset;
  logic [31:0]   data_in;
  logic          data_in_valid, data_in_last;
  logic [2:0]    data_in_nbytes;
  logic          data_in_ready;
  logic [7:0]    byte_out;
  logic          byte_out_valid, byte_out_ready, byte_out_last;
  logic [CW-1:0] byte_count, stuff_count;

  logic          valid0;
  logic          ready0;
  logic [7:0]    byte0;
  logic          bvalid0, blast0;
  logic [CW-1:0] bcount0, scount0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] cap_byte[$];
  logic       cap_last[$];
  logic [7:0] exp_q[$];
  logic       prev_stalled = 1'b0;
  logic [7:0] prev_byte;
  logic       prev_last;
  int         base;
  int         bc_base, sc_base;

  always #5 clock = ~clock;

  jfpjc_byte_stuffer #(.APPEND_EOI(1'b1), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_in_last(data_in_last), .data_in_nbytes(data_in_nbytes),
    .byte_out(byte_out), .byte_out_valid(byte_out_valid), .byte_out_ready(byte_out_ready),
    .byte_out_last(byte_out_last), .byte_count(byte_count), .stuff_count(stuff_count)
  );

  jfpjc_byte_stuffer #(.APPEND_EOI(1'b0), .COUNT_WIDTH(CW)) dut0 (
    .clock(clock), .reset(reset),
    .data_in(data_in), .data_in_valid(valid0), .data_in_ready(ready0),
    .data_in_last(data_in_last), .data_in_nbytes(data_in_nbytes),
    .byte_out(byte0), .byte_out_valid(bvalid0), .byte_out_ready(byte_out_ready),
    .byte_out_last(blast0), .byte_count(bcount0), .stuff_count(scount0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Records every handoff and checks outputs hold steady while stalled.
  always @(negedge clock) begin
    if (reset) begin
      prev_stalled = 1'b0;
    end else begin
      if (prev_stalled)
        check("stall_hold", {22'd0, byte_out_valid, byte_out_last, byte_out},
              {22'd0, 1'b1, prev_last, prev_byte});
      if (byte_out_valid && byte_out_ready) begin
        cap_byte.push_back(byte_out);
        cap_last.push_back(byte_out_last);
      end
      prev_stalled = byte_out_valid && !byte_out_ready;
      prev_byte    = byte_out;
      prev_last    = byte_out_last;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input logic l, input logic [2:0] nb);
    int n = 0;
    while (!data_in_ready && n < 50) begin
      step();
      n++;
    end
    if (!data_in_ready) check("send_timeout", 32'd0, 32'd1);
    data_in        = w;
    data_in_last   = l;
    data_in_nbytes = nb;
    data_in_valid  = 1'b1;
    step();
    data_in_valid  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (!(data_in_ready && !byte_out_valid) && n < 100) begin
      step();
      n++;
    end
    if (!(data_in_ready && !byte_out_valid)) check("drain_timeout", 32'd0, 32'd1);
  endtask

  // Compares captured bytes from index b against exp_q; last expected only at last_idx.
  task automatic expect_bytes(input string tag, input int b, input int last_idx);
    check({tag, "_len"}, 32'(cap_byte.size() - b), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (b + i < cap_byte.size()) begin
        check($sformatf("%s_b%0d", tag, i), 32'(cap_byte[b+i]), 32'(exp_q[i]));
        check($sformatf("%s_l%0d", tag, i), 32'(cap_last[b+i]), 32'(i == last_idx));
      end
    end
  endtask

  initial begin
    reset = 1'b1; data_in = '0; data_in_valid = 1'b0; data_in_last = 1'b0;
    data_in_nbytes = 3'd0; byte_out_ready = 1'b1; valid0 = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_byte",  32'(byte_out), 32'h0);
    check("rst_valid", 32'(byte_out_valid), 32'h0);
    check("rst_last",  32'(byte_out_last), 32'h0);
    check("rst_ready", 32'(data_in_ready), 32'h1);
    check("rst_bcnt",  32'(byte_count), 32'h0);
    check("rst_scnt",  32'(stuff_count), 32'h0);

    // 1: plain word, one byte per cycle, ready low while emitting
    base = cap_byte.size();
    send_word(32'h04030201, 1'b0, 3'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_byte%0d", i), 32'(byte_out), 32'(i + 1));
      check($sformatf("t1_rdy%0d", i), 32'(data_in_ready), 32'h0);
      step();
    end
    check("t1_idle_rdy", 32'(data_in_ready), 32'h1);
    check("t1_idle_vld", 32'(byte_out_valid), 32'h0);
    check("t1_bcnt", 32'(byte_count), 32'd4);
    check("t1_scnt", 32'(stuff_count), 32'd0);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    expect_bytes("t1", base, -1);

    // 2: stuffing after 0xFF lanes
    base = cap_byte.size(); bc_base = int'(byte_count); sc_base = int'(stuff_count);
    send_word(32'h00FF00FF, 1'b0, 3'd4);
    drain();
    exp_q = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
    expect_bytes("t2", base, -1);
    check("t2_bcnt", 32'(int'(byte_count) - bc_base), 32'd6);
    check("t2_scnt", 32'(int'(stuff_count) - sc_base), 32'd2);

    // 3: all-0xFF word with sink toggling ready
    base = cap_byte.size(); sc_base = int'(stuff_count);
    send_word(32'hFFFFFFFF, 1'b0, 3'd4);
    for (int n = 0; n < 60 && !(data_in_ready && !byte_out_valid); n++) begin
      byte_out_ready = ~byte_out_ready;
      step();
    end
    byte_out_ready = 1'b1;
    drain();
    exp_q = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
    expect_bytes("t3", base, -1);
    check("t3_scnt", 32'(int'(stuff_count) - sc_base), 32'd4);

    // 4: partial last word followed by EOI
    base = cap_byte.size();
    send_word(32'h3322BBAA, 1'b1, 3'd2);
    drain();
    exp_q = '{8'hAA, 8'hBB, 8'hFF, 8'hD9};
    expect_bytes("t4", base, 3);

    // 4b: oversized nbytes clamps to four
    base = cap_byte.size();
    send_word(32'h04030201, 1'b1, 3'd7);
    drain();
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hD9};
    expect_bytes("t4b", base, 5);

    // 5: reset while presenting a stuff byte
    send_word(32'hFFFFFFFF, 1'b0, 3'd4);
    step();
    check("t5_in_stuff", 32'(byte_out), 32'h00);
    byte_out_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    byte_out_ready = 1'b1;
    check("t5_valid", 32'(byte_out_valid), 32'h0);
    check("t5_ready", 32'(data_in_ready), 32'h1);
    check("t5_bcnt",  32'(byte_count), 32'h0);
    check("t5_scnt",  32'(stuff_count), 32'h0);
    base = cap_byte.size();
    send_word(32'h04030201, 1'b0, 3'd4);
    drain();
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    expect_bytes("t5", base, -1);
    check("t5_bcnt_after", 32'(byte_count), 32'd4);

    // 6: empty last word yields bare EOI
    base = cap_byte.size();
    send_word(32'hDEADBEEF, 1'b1, 3'd0);
    drain();
    exp_q = '{8'hFF, 8'hD9};
    expect_bytes("t6", base, 1);

    // 6b: without EOI an empty last word produces nothing
    data_in = 32'hDEADBEEF; data_in_last = 1'b1; data_in_nbytes = 3'd0; valid0 = 1'b1;
    step();
    valid0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t6b_rdy%0d", i), 32'(ready0), 32'h1);
      check($sformatf("t6b_vld%0d", i), 32'(bvalid0), 32'h0);
      step();
    end
    check("t6b_bcnt", 32'(bcount0), 32'h0);

    // 6c: without EOI, last flag lands on the stuffing byte of a final 0xFF
    data_in = 32'h0000FF11; data_in_last = 1'b1; data_in_nbytes = 3'd2; valid0 = 1'b1;
    step();
    valid0 = 1'b0;
    check("t6c_b0", {23'd0, blast0, byte0}, {23'd0, 1'b0, 8'h11});
    step();
    check("t6c_b1", {23'd0, blast0, byte0}, {23'd0, 1'b0, 8'hFF});
    step();
    check("t6c_b2", {23'd0, blast0, byte0}, {23'd0, 1'b1, 8'h00});
    step();
    check("t6c_idle", 32'(bvalid0), 32'h0);
    check("t6c_scnt", 32'(scount0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
